fetch_pc_ctrl: RTL and testbench

Fetch-stage PC controller. It sits directly upstream of the two-bit dynamic branch predictor and feeds it PC_f and the fetched instruction word (RD). It owns the PC register and selects the next PC from three sources: execute-stage redirect, predictor target, or PC+4. It sequences instruction-cache misses and squashes any wrong-path fetch that is still outstanding when a redirect arrives.

---
 rtl/fetch_pc_ctrl_if.sv | 23 ++
 rtl/fetch_pc_ctrl.sv | 94 +++++++++
 tb/tb_fetch_pc_ctrl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pc_ctrl_if.sv
// Instruction-cache fetch channel between the fetch PC controller (master) and the cache (slave).
interface fetch_pc_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  icache_req;
  logic [DATA_WIDTH-1:0] icache_addr;
  logic                  icache_ready;
  logic [DATA_WIDTH-1:0] icache_data;

  modport master (
    output icache_req,
    output icache_addr,
    input  icache_ready,
    input  icache_data
  );

  modport slave (
    input  icache_req,
    input  icache_addr,
    output icache_ready,
    output icache_data
  );
endinterface

// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage PC controller: next-PC select (redirect / predicted target / PC+4), I-cache miss
// sequencing and wrong-path squash. Optional FETCH_PERF_CNT_EN adds saturating miss/redirect counters.
module fetch_pc_ctrl #(
  parameter int unsigned                DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0]      RESET_PC   = '0,
  parameter logic [DATA_WIDTH-1:0]      NOP_INSTR  = DATA_WIDTH'(32'h0000_0013)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_f,
  fetch_pc_ctrl_if.master       icache,
  input  logic                  predict_taken_f,
  input  logic [DATA_WIDTH-1:0] branch_target_f,
  input  logic                  redirect_e,
  input  logic [DATA_WIDTH-1:0] redirect_pc_e,
  output logic [DATA_WIDTH-1:0] PC_f,
  output logic [DATA_WIDTH-1:0] instr_f,
  output logic                  instr_valid_f,
  output logic [DATA_WIDTH-1:0] pc_plus4_f
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]           perf_miss_cycles,
  output logic [31:0]           perf_redirects
`endif
);

  typedef enum logic [1:0] {
    RUN,
    MISS,
    SQUASH
  } state_t;

  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);

  state_t                state;
  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] held_pc;
  logic [DATA_WIDTH-1:0] pc_plus4;
  logic                  data_ok;

  assign pc_plus4 = pc_q + DATA_WIDTH'(4);

  // A returned word is correct-path only outside SQUASH and when execute is not redirecting.
  assign data_ok       = (state != SQUASH) && icache.icache_ready && !redirect_e;
  assign instr_valid_f = rst && data_ok;
  assign instr_f       = instr_valid_f ? icache.icache_data : NOP_INSTR;

  assign icache.icache_req  = rst;
  assign icache.icache_addr = pc_q;
  assign PC_f               = pc_q;
  assign pc_plus4_f         = pc_plus4;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= RUN;
      pc_q    <= RESET_PC;
      held_pc <= '0;
    end else if (icache.icache_ready) begin
      state <= RUN;
      if (redirect_e) begin
        pc_q <= redirect_pc_e & ALIGN_MASK;
      end else if (state == SQUASH) begin
        pc_q <= held_pc;
      end else if (!stall_f) begin
        pc_q <= predict_taken_f ? (branch_target_f & ALIGN_MASK) : (pc_plus4 & ALIGN_MASK);
      end
    end else begin
      // Request still outstanding: PC held; a redirect is parked until the old access completes.
      if (redirect_e) begin
        held_pc <= redirect_pc_e & ALIGN_MASK;
        state   <= SQUASH;
      end else if (state == RUN) begin
        state <= MISS;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_miss_cycles <= '0;
      perf_redirects   <= '0;
    end else begin
      if (((state != RUN) || !icache.icache_ready) && (perf_miss_cycles != '1)) begin
        perf_miss_cycles <= perf_miss_cycles + 32'd1;
      end
      if (redirect_e && (perf_redirects != '1)) begin
        perf_redirects <= perf_redirects + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Self-checking bench for fetch_pc_ctrl: directed scenarios plus randomized traffic against a
// transaction-level model (PC plus a list of parked redirects).
module tb_fetch_pc_ctrl;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_f = 1'b0;
  logic        predict_taken_f = 1'b0;
  logic        redirect_e = 1'b0;
  logic [31:0] branch_target_f = '0;
  logic [31:0] redirect_pc_e = '0;
  logic [31:0] PC_f, instr_f, pc_plus4_f;
  logic        instr_valid_f;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_miss_cycles, perf_redirects;
`endif

  fetch_pc_ctrl_if #(.DATA_WIDTH(32)) bus ();

  fetch_pc_ctrl #(
    .DATA_WIDTH(32),
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (NOP)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall_f        (stall_f),
    .icache         (bus),
    .predict_taken_f(predict_taken_f),
    .branch_target_f(branch_target_f),
    .redirect_e     (redirect_e),
    .redirect_pc_e  (redirect_pc_e),
    .PC_f           (PC_f),
    .instr_f        (instr_f),
    .instr_valid_f  (instr_valid_f),
    .pc_plus4_f     (pc_plus4_f)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_miss_cycles(perf_miss_cycles),
    .perf_redirects  (perf_redirects)
`endif
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_pend[$];
  logic        m_prev_nr;
  logic [31:0] m_miss, m_redir;

  // Observed / expected values for the most recent cycle
  logic [31:0] obs_pc, obs_instr, obs_addr, obs_p4;
  logic        obs_valid, obs_req;
  logic [31:0] exp_pc, exp_instr;
  logic        exp_valid;

  task automatic model_reset();
    m_pc = 32'h0;
    m_pend.delete();
    m_prev_nr = 1'b0;
    m_miss = 0;
    m_redir = 0;
  endtask

  // One clock: drive inputs, sample at negedge, advance model at posedge.
  task automatic cycle(input logic s, input logic r, input logic [31:0] d, input logic p,
                       input logic [31:0] t, input logic rd, input logic [31:0] rp);
    stall_f = s; bus.icache_ready = r; bus.icache_data = d;
    predict_taken_f = p; branch_target_f = t; redirect_e = rd; redirect_pc_e = rp;
    @(negedge clk);
    obs_pc = PC_f; obs_instr = instr_f; obs_valid = instr_valid_f;
    obs_addr = bus.icache_addr; obs_p4 = pc_plus4_f; obs_req = bus.icache_req;
    exp_pc    = m_pc;
    exp_valid = r && !rd && (m_pend.size() == 0);
    exp_instr = exp_valid ? d : NOP;
    @(posedge clk);
    if (r) begin
      if (rd) m_pc = rp & 32'hFFFF_FFFC;
      else if (m_pend.size() > 0) m_pc = m_pend[$];
      else if (s) m_pc = m_pc;
      else if (p) m_pc = t & 32'hFFFF_FFFC;
      else m_pc = m_pc + 32'd4;
      m_pend.delete();
    end else if (rd) begin
      m_pend.push_back(rp & 32'hFFFF_FFFC);
    end
    if ((!r || m_prev_nr) && m_miss != 32'hFFFF_FFFF) m_miss = m_miss + 1;
    if (rd && m_redir != 32'hFFFF_FFFF) m_redir = m_redir + 1;
    m_prev_nr = !r;
    #1;
  endtask

  task automatic redirect_to(input logic [31:0] a);
    cycle(1'b0, 1'b1, $urandom, 1'b0, 32'h0, 1'b1, a);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.icache_ready = 1'b1; bus.icache_data = 32'h0000_0063;
    #2;
    checks++; if (PC_f !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp %h", PC_f, 32'h0); end
    checks++; if (bus.icache_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", bus.icache_req); end
    checks++; if (instr_valid_f !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", instr_valid_f); end
    checks++; if (instr_f !== NOP) begin errors++; $display("FAIL reset_instr got %h exp %h", instr_f, NOP); end
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 4; i++) begin
      logic [31:0] d;
      d = $urandom;
      cycle(1'b0, 1'b1, d, 1'b0, 32'h0, 1'b0, 32'h0);
      checks++; if (obs_pc !== 32'(i * 4)) begin errors++; $display("FAIL seq_pc[%0d] got %h exp %h", i, obs_pc, 32'(i * 4)); end
      checks++; if (obs_valid !== 1'b1 || obs_instr !== d) begin errors++; $display("FAIL seq_instr[%0d] got %b/%h exp 1/%h", i, obs_valid, obs_instr, d); end
      checks++; if (obs_req !== 1'b1 || obs_addr !== 32'(i * 4)) begin errors++; $display("FAIL seq_req[%0d] got %b/%h exp 1/%h", i, obs_req, obs_addr, 32'(i * 4)); end
    end
  endtask

  task automatic test_branch_redirect();
    redirect_to(32'h10);
    cycle(1'b0, 1'b1, 32'h1234_5678, 1'b1, 32'h40, 1'b0, 32'h0);
    checks++; if (obs_pc !== 32'h10 || obs_valid !== 1'b1) begin errors++; $display("FAIL br_pc got %h/%b exp 00000010/1", obs_pc, obs_valid); end
    cycle(1'b0, 1'b1, 32'h0000_0063, 1'b1, 32'h44, 1'b1, 32'h80);
    checks++; if (obs_pc !== 32'h40) begin errors++; $display("FAIL br_target got %h exp 00000040", obs_pc); end
    checks++; if (obs_valid !== 1'b0 || obs_instr !== NOP) begin errors++; $display("FAIL br_squash got %b/%h exp 0/%h", obs_valid, obs_instr, NOP); end
    cycle(1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++; if (obs_pc !== 32'h80) begin errors++; $display("FAIL br_redirect got %h exp 00000080", obs_pc); end
  endtask

  task automatic test_miss();
    redirect_to(32'h20);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, $urandom, 1'b0, 32'h0, 1'b0, 32'h0);
      checks++; if (obs_pc !== 32'h20 || obs_valid !== 1'b0 || obs_instr !== NOP) begin
        errors++; $display("FAIL miss_hold[%0d] got %h/%b/%h exp 00000020/0/%h", i, obs_pc, obs_valid, obs_instr, NOP);
      end
    end
    cycle(1'b0, 1'b1, 32'hCAFE_0013, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++; if (obs_pc !== 32'h20 || obs_valid !== 1'b1 || obs_instr !== 32'hCAFE_0013) begin
      errors++; $display("FAIL miss_done got %h/%b/%h exp 00000020/1/cafe0013", obs_pc, obs_valid, obs_instr);
    end
    cycle(1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++; if (obs_pc !== 32'h24) begin errors++; $display("FAIL miss_next got %h exp 00000024", obs_pc); end
  endtask

  task automatic test_miss_redirect();
    redirect_to(32'h20);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h100);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'h300, 1'b0, 32'h0);
    checks++; if (obs_pc !== 32'h20 || obs_valid !== 1'b0 || obs_instr !== NOP) begin
      errors++; $display("FAIL sq_drop got %h/%b/%h exp 00000020/0/%h", obs_pc, obs_valid, obs_instr, NOP);
    end
    cycle(1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++; if (obs_pc !== 32'h100) begin errors++; $display("FAIL sq_pc got %h exp 00000100", obs_pc); end
  endtask

  task automatic test_stall_redirect();
    redirect_to(32'h30);
    cycle(1'b1, 1'b1, 32'h0000_1111, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++; if (obs_pc !== 32'h30 || obs_valid !== 1'b1 || obs_instr !== 32'h0000_1111) begin
      errors++; $display("FAIL stall_hold got %h/%b/%h exp 00000030/1/00001111", obs_pc, obs_valid, obs_instr);
    end
    cycle(1'b1, 1'b1, 32'h0000_1111, 1'b0, 32'h0, 1'b1, 32'h200);
    checks++; if (obs_pc !== 32'h30 || obs_valid !== 1'b0) begin errors++; $display("FAIL stall_redir got %h/%b exp 00000030/0", obs_pc, obs_valid); end
    cycle(1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++; if (obs_pc !== 32'h200) begin errors++; $display("FAIL stall_new got %h exp 00000200", obs_pc); end
  endtask

  task automatic test_wrap();
    redirect_to(32'hFFFF_FFFF);
    cycle(1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++; if (obs_pc !== 32'hFFFF_FFFC || obs_p4 !== 32'h0) begin errors++; $display("FAIL wrap_top got %h/%h exp fffffffc/00000000", obs_pc, obs_p4); end
    cycle(1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++; if (obs_pc !== 32'h0) begin errors++; $display("FAIL wrap_zero got %h exp 00000000", obs_pc); end
  endtask

  task automatic test_reset_mid_miss();
    redirect_to(32'h20);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    bus.icache_ready = 1'b1;
    rst = 1'b0;
    #1;
    checks++; if (PC_f !== 32'h0 || bus.icache_req !== 1'b0 || instr_valid_f !== 1'b0) begin
      errors++; $display("FAIL rstmiss_async got %h/%b/%b exp 00000000/0/0", PC_f, bus.icache_req, instr_valid_f);
    end
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    cycle(1'b0, 1'b1, 32'h0000_0555, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++; if (obs_pc !== 32'h0 || obs_valid !== 1'b1 || obs_req !== 1'b1) begin
      errors++; $display("FAIL rstmiss_run got %h/%b/%b exp 00000000/1/1", obs_pc, obs_valid, obs_req);
    end
    cycle(1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++; if (obs_pc !== 32'h4) begin errors++; $display("FAIL rstmiss_next got %h exp 00000004", obs_pc); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic s, r, p, rd;
      s  = ($urandom_range(0, 4) == 0);
      r  = ($urandom_range(0, 9) < 7);
      p  = ($urandom_range(0, 3) == 0);
      rd = ($urandom_range(0, 9) == 0);
      cycle(s, r, $urandom, p, $urandom, rd, $urandom);
      checks++; if (obs_pc !== exp_pc) begin errors++; $display("FAIL rnd_pc[%0d] got %h exp %h", i, obs_pc, exp_pc); end
      checks++; if (obs_addr !== exp_pc) begin errors++; $display("FAIL rnd_addr[%0d] got %h exp %h", i, obs_addr, exp_pc); end
      checks++; if (obs_p4 !== exp_pc + 32'd4) begin errors++; $display("FAIL rnd_p4[%0d] got %h exp %h", i, obs_p4, exp_pc + 32'd4); end
      checks++; if (obs_valid !== exp_valid) begin errors++; $display("FAIL rnd_valid[%0d] got %b exp %b", i, obs_valid, exp_valid); end
      checks++; if (obs_instr !== exp_instr) begin errors++; $display("FAIL rnd_instr[%0d] got %h exp %h", i, obs_instr, exp_instr); end
    end
`ifdef FETCH_PERF_CNT_EN
    checks++; if (perf_miss_cycles !== m_miss) begin errors++; $display("FAIL perf_miss got %0d exp %0d", perf_miss_cycles, m_miss); end
    checks++; if (perf_redirects !== m_redir) begin errors++; $display("FAIL perf_redir got %0d exp %0d", perf_redirects, m_redir); end
`endif
  endtask

  initial begin
    model_reset();
    test_reset();
    test_sequential();
    test_branch_redirect();
    test_miss();
    test_miss_redirect();
    test_stall_redirect();
    test_wrap();
    test_reset_mid_miss();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
